mips_mem_sequencer: RTL and testbench

//  Multi-cycle sequencer that shares one single-port handshaked memory between instruction fetch and data access of mod_mips_processor.

---
 rtl/mips_mem_sequencer_pkg.sv | 18 +
 rtl/mips_mem_sequencer_if.sv | 22 ++
 rtl/mem_seq_watchdog.sv | 34 +++
 rtl/mips_mem_sequencer.sv | 112 +++++++++++
 tb/tb_mips_mem_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_sequencer_pkg.sv
// Shared state encoding and helpers for the MIPS unified-memory sequencer.
package mips_mem_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_DATA   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_HALTED = 3'd5,
        ST_ERROR  = 3'd6
    } seq_state_e;

    function automatic logic is_bus_state(seq_state_e s);
        return (s == ST_FETCH) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/mips_mem_sequencer_if.sv
// Single-port handshaked memory bus between the sequencer (master) and memory (slave).
interface mips_mem_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_seq_watchdog.sv
// Per-transaction watchdog: counts unacknowledged request cycles and flags expiry.
module mem_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_req,
    input  logic mem_ack,
    output logic expire
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q, count_d;

    // FETCH and DATA are always separated by a non-request cycle, so
    // clearing whenever mem_req is low clears on every transaction entry.
    always_comb begin
        count_d = '0;
        if (mem_req && !mem_ack) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = mem_req && !mem_ack &&
                    (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mips_mem_sequencer.sv
// Multi-cycle fetch/exec/data/commit sequencer sharing one memory port for mod_mips_processor.
// Optional watchdog and ERROR state enabled with `define MEM_SEQ_TIMEOUT_EN.
module mips_mem_sequencer
    import mips_mem_sequencer_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    pc,
    input  logic [ADDR_W-1:0]    cpu_data_address,
    input  logic [DATA_W-1:0]    cpu_write_data,
    input  logic                 cpu_mem_read,
    input  logic                 cpu_mem_write,
    output logic [DATA_W-1:0]    cpu_instruction,
    output logic [DATA_W-1:0]    cpu_data,
    output logic                 cpu_hold,
    mips_mem_sequencer_if.master mem,
    input  logic                 halt_req,
    output logic                 halted,
    output logic                 instr_retired,
    output logic                 bus_error
);
    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] cpu_instruction_q, cpu_instruction_d;
    logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
    logic              op_we_q, op_we_d;
    logic              expire;

`ifdef MEM_SEQ_TIMEOUT_EN
    mem_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .mem_req (mem.mem_req),
        .mem_ack (mem.mem_ack),
        .expire  (expire)
    );
    assign bus_error = (state_q == ST_ERROR);
`else
    wire unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign expire    = 1'b0;
    assign bus_error = 1'b0;
`endif

    always_comb begin
        state_d           = state_q;
        cpu_instruction_d = cpu_instruction_q;
        cpu_data_d        = cpu_data_q;
        op_we_d           = op_we_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem.mem_ack) begin
                    cpu_instruction_d = mem.mem_rdata;
                    state_d           = ST_EXEC;
                end else if (expire) begin
                    state_d = ST_ERROR;
                end
            end
            ST_EXEC: begin
                // Write wins when both strobes are set.
                op_we_d = cpu_mem_write;
                state_d = (cpu_mem_read || cpu_mem_write) ? ST_DATA : ST_COMMIT;
            end
            ST_DATA: begin
                if (mem.mem_ack) begin
                    if (!op_we_q) begin
                        cpu_data_d = mem.mem_rdata;
                    end
                    state_d = ST_COMMIT;
                end else if (expire) begin
                    state_d = ST_ERROR;
                end
            end
            ST_COMMIT: state_d = halt_req ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_d = halt_req ? ST_HALTED : ST_FETCH;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            cpu_instruction_q <= '0;
            cpu_data_q        <= '0;
            op_we_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            cpu_instruction_q <= cpu_instruction_d;
            cpu_data_q        <= cpu_data_d;
            op_we_q           <= op_we_d;
        end
    end

    // The processor is held throughout a transaction, so pc and the data
    // operands stay stable for as long as mem_req is high.
    assign mem.mem_req   = is_bus_state(state_q);
    assign mem.mem_we    = (state_q == ST_DATA) && op_we_q;
    assign mem.mem_addr  = (state_q == ST_DATA) ? cpu_data_address : pc;
    assign mem.mem_wdata = cpu_write_data;

    assign cpu_instruction = cpu_instruction_q;
    assign cpu_data        = cpu_data_q;
    assign cpu_hold        = (state_q != ST_COMMIT);
    assign instr_retired   = (state_q == ST_COMMIT);
    assign halted          = (state_q == ST_HALTED);
endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Self-checking bench: bench plays processor and memory, checks each cycle against instruction-level rules.
module tb_mips_mem_sequencer;
`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] cpu_data_address;
    logic [31:0] cpu_write_data;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic [31:0] cpu_instruction;
    logic [31:0] cpu_data;
    logic        cpu_hold;
    logic        halt_req;
    logic        halted;
    logic        instr_retired;
    logic        bus_error;

    mips_mem_sequencer_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    mips_mem_sequencer #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .cpu_data_address (cpu_data_address),
        .cpu_write_data   (cpu_write_data),
        .cpu_mem_read     (cpu_mem_read),
        .cpu_mem_write    (cpu_mem_write),
        .cpu_instruction  (cpu_instruction),
        .cpu_data         (cpu_data),
        .cpu_hold         (cpu_hold),
        .mem              (mem_if),
        .halt_req         (halt_req),
        .halted           (halted),
        .instr_retired    (instr_retired),
        .bus_error        (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Processor model: pc advances once per released hold.
    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 32'd0;
        else if (!cpu_hold) pc <= pc + 32'd4;
    end

    int rd_cnt = 0;
    int wr_cnt = 0;
    always @(posedge clk) begin
        if (mem_if.mem_req && mem_if.mem_ack) begin
            if (mem_if.mem_we) wr_cnt <= wr_cnt + 1;
            else               rd_cnt <= rd_cnt + 1;
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc_exp   = 32'd0;
    logic [31:0] exp_data = 32'd0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // kind: 0=alu, 1=load, 2=store, 3=read+write (behaves as store).
    // Entered at the negedge of the first FETCH cycle; leaves one cycle after COMMIT.
    task automatic run_instr(input int kind, input int fw, input int dw,
                             input logic [31:0] daddr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input bit halt, input bit abort);
        logic [31:0] instr;
        bit          is_load;
        bit          is_store;
        int          rd0;
        int          wr0;
        instr    = $urandom;
        is_load  = (kind == 1);
        is_store = (kind >= 2);
        rd0      = rd_cnt;
        wr0      = wr_cnt;
        cpu_mem_read     = (kind == 1) || (kind == 3);
        cpu_mem_write    = (kind == 2) || (kind == 3);
        cpu_data_address = daddr;
        cpu_write_data   = wdata;
        for (int w = 0; w <= fw; w++) begin
            chk1 ("fetch_req",  mem_if.mem_req, 1'b1);
            chk1 ("fetch_we",   mem_if.mem_we, 1'b0);
            chk32("fetch_addr", mem_if.mem_addr, pc_exp);
            chk1 ("fetch_hold", cpu_hold, 1'b1);
            if (halt && w == 0) halt_req = 1'b1;
            mem_if.mem_ack   = (w == fw);
            mem_if.mem_rdata = (w == fw) ? instr : $urandom;
            @(negedge clk);
        end
        mem_if.mem_ack = 1'b0;
        chk1 ("exec_req",   mem_if.mem_req, 1'b0);
        chk32("exec_instr", cpu_instruction, instr);
        chk1 ("exec_hold",  cpu_hold, 1'b1);
        chk1 ("exec_ret",   instr_retired, 1'b0);
        @(negedge clk);
        if (kind != 0) begin
            for (int w = 0; w <= dw; w++) begin
                chk1 ("data_req",  mem_if.mem_req, 1'b1);
                chk1 ("data_we",   mem_if.mem_we, is_store);
                chk32("data_addr", mem_if.mem_addr, daddr);
                chk1 ("data_hold", cpu_hold, 1'b1);
                if (is_store) chk32("data_wdata", mem_if.mem_wdata, wdata);
                if (abort && w == 1) begin
                    #2 reset = 1'b1;
                    #1;
                    chk1 ("rst_req",   mem_if.mem_req, 1'b0);
                    chk1 ("rst_ret",   instr_retired, 1'b0);
                    chk1 ("rst_hold",  cpu_hold, 1'b1);
                    chk32("rst_instr", cpu_instruction, 32'd0);
                    chk32("rst_data",  cpu_data, 32'd0);
                    @(negedge clk);
                    reset         = 1'b0;
                    pc_exp        = 32'd0;
                    exp_data      = 32'd0;
                    cpu_mem_read  = 1'b0;
                    cpu_mem_write = 1'b0;
                    chk1 ("idle_req",  mem_if.mem_req, 1'b0);
                    chk1 ("idle_ret",  instr_retired, 1'b0);
                    chk1 ("idle_hold", cpu_hold, 1'b1);
                    @(negedge clk);
                    return;
                end
                mem_if.mem_ack   = (w == dw);
                mem_if.mem_rdata = (w == dw) ? rdata : $urandom;
                @(negedge clk);
            end
            mem_if.mem_ack = 1'b0;
            if (is_load) exp_data = rdata;
        end
        chk1 ("commit_ret",   instr_retired, 1'b1);
        chk1 ("commit_hold",  cpu_hold, 1'b0);
        chk1 ("commit_req",   mem_if.mem_req, 1'b0);
        chk1 ("commit_halt",  halted, 1'b0);
        chk1 ("commit_berr",  bus_error, 1'b0);
        chk32("commit_instr", cpu_instruction, instr);
        chk32("commit_data",  cpu_data, exp_data);
        chk32("reads",        32'(rd_cnt - rd0), is_load ? 32'd2 : 32'd1);
        chk32("writes",       32'(wr_cnt - wr0), is_store ? 32'd1 : 32'd0);
        pc_exp = pc_exp + 32'd4;
        @(negedge clk);
    endtask

    initial begin
        reset            = 1'b1;
        halt_req         = 1'b0;
        cpu_mem_read     = 1'b0;
        cpu_mem_write    = 1'b0;
        cpu_data_address = 32'd0;
        cpu_write_data   = 32'd0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk1 ("rst0_req",   mem_if.mem_req, 1'b0);
        chk1 ("rst0_we",    mem_if.mem_we, 1'b0);
        chk1 ("rst0_hold",  cpu_hold, 1'b1);
        chk1 ("rst0_halt",  halted, 1'b0);
        chk1 ("rst0_ret",   instr_retired, 1'b0);
        chk1 ("rst0_berr",  bus_error, 1'b0);
        chk32("rst0_instr", cpu_instruction, 32'd0);
        chk32("rst0_data",  cpu_data, 32'd0);
        reset = 1'b0;
        chk1("idle0_req", mem_if.mem_req, 1'b0);
        @(negedge clk);

        // Zero-wait ALU, zero-wait load/store, then waited variants.
        run_instr(0, 0, 0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        run_instr(1, 2, 2, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_instr(0, 1, 0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        run_instr(2, 1, 3, 32'h0000_0040, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        run_instr(3, 0, 1, 32'h0000_0080, 32'hCAFE_0001, 32'h5555_5555, 1'b0, 1'b0);
        run_instr(1, 0, 0, 32'h0000_0044, 32'd0, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Halt raised during FETCH: instruction completes, then parks.
        run_instr(1, 1, 1, 32'h0000_0200, 32'd0, 32'h1357_9BDF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk1 ("halt_flag", halted, 1'b1);
            chk1 ("halt_req0", mem_if.mem_req, 1'b0);
            chk1 ("halt_hold", cpu_hold, 1'b1);
            chk1 ("halt_ret",  instr_retired, 1'b0);
            chk32("halt_pc",   pc, pc_exp);
            @(negedge clk);
        end
        chk1("halt_last", halted, 1'b1);
        halt_req = 1'b0;
        @(negedge clk);
        run_instr(0, 0, 0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Reset during a DATA wait abandons the instruction.
        run_instr(1, 0, 3, 32'h0000_0300, 32'd0, 32'h7777_7777, 1'b0, 1'b1);
        run_instr(0, 0, 0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC,
                      $urandom, $urandom, 1'b0, 1'b0);
        end

`ifdef MEM_SEQ_TIMEOUT_EN
        // Memory never answers: watchdog trips after TO request cycles.
        for (int w = 0; w < int'(TO); w++) begin
            chk1 ("to_req",  mem_if.mem_req, 1'b1);
            chk1 ("to_berr", bus_error, 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            chk1("err_berr", bus_error, 1'b1);
            chk1("err_req",  mem_if.mem_req, 1'b0);
            chk1("err_hold", cpu_hold, 1'b1);
            chk1("err_ret",  instr_retired, 1'b0);
            mem_if.mem_ack = i[0];
            @(negedge clk);
        end
        mem_if.mem_ack = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        pc_exp = 32'd0;
        chk1("err_clear", bus_error, 1'b0);
        @(negedge clk);
        run_instr(0, 0, 0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
